stream_source: RTL

//  Parametrised valid/ready stimulus source for the source/sink test fabric.

---
 rtl/stream_source.sv | 125 ++++++++++++
 1 files changed

// File: rtl/stream_source.sv
// rtl/stream_source.sv - valid/ready stimulus source with gap, data modes and packet framing
// Optional LFSR data mode is built only when STREAM_SOURCE_LFSR_EN is defined.
module stream_source #(
   parameter int unsigned       DATA_W    = 8,
   parameter int unsigned       GAP       = 4,
   parameter int unsigned       PKT_LEN   = 4,
   parameter logic [DATA_W-1:0] SEED      = '0,
   parameter logic [DATA_W-1:0] LFSR_TAPS = 'hB8,
   parameter int unsigned       CNT_W     = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              enable_i,
   input  logic [1:0]        mode_i,
   input  logic              ready_i,
   output logic              valid_o,
   output logic [DATA_W-1:0] data_o,
   output logic              last_o,
   output logic [CNT_W-1:0]  beats_o
);

   localparam logic [0:0] ST_GAP   = 1'b0;
   localparam logic [0:0] ST_VALID = 1'b1;

   localparam int unsigned GAP_W = (GAP < 2) ? 1 : $clog2(GAP + 1);
   localparam int unsigned IDX_W = (PKT_LEN < 2) ? 1 : $clog2(PKT_LEN);

   localparam logic [GAP_W-1:0] GAP_END  = GAP_W'(GAP);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_LEN - 1);
   localparam logic             LAST_RST = (PKT_LEN == 1);

   logic [0:0]        state_q, state_d;
   logic [GAP_W-1:0]  gap_q, gap_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [DATA_W-1:0] data_q, data_d, data_next;
   logic              last_q, last_d;
   logic [CNT_W-1:0]  beats_q, beats_d;
   logic              handshake;

   // Galois step; an all-zero register would stick, so it is kicked to 1.
   function automatic logic [DATA_W-1:0] lfsr_step(input logic [DATA_W-1:0] d);
      if (d == '0) begin
         return DATA_W'(1);
      end
      return (d >> 1) ^ (d[0] ? LFSR_TAPS : '0);
   endfunction

   always_comb begin
      data_next = data_q;
      unique case (mode_i)
         2'b00: data_next = data_q + DATA_W'(1);
`ifdef STREAM_SOURCE_LFSR_EN
         2'b01: data_next = lfsr_step(data_q);
`else
         2'b01: data_next = data_q + DATA_W'(1);
`endif
         2'b10: data_next = data_q;
         default: data_next = data_q - DATA_W'(1);
      endcase
   end

   assign handshake = (state_q == ST_VALID) && ready_i;

   always_comb begin
      state_d = state_q;
      gap_d   = gap_q;
      idx_d   = idx_q;
      data_d  = data_q;
      last_d  = last_q;
      beats_d = beats_q;
      unique case (state_q)
         ST_GAP: begin
            if (enable_i) begin
               if ((GAP == 0) || (gap_q + GAP_W'(1) == GAP_END)) begin
                  state_d = ST_VALID;
                  gap_d   = '0;
               end else begin
                  gap_d = gap_q + GAP_W'(1);
               end
            end
         end
         ST_VALID: begin
            // Beat is frozen until accepted; enable_i has no say here.
            if (handshake) begin
               beats_d = beats_q + CNT_W'(1);
               idx_d   = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
               last_d  = (idx_d == LAST_IDX);
               data_d  = data_next;
               if (GAP != 0) begin
                  state_d = ST_GAP;
                  gap_d   = '0;
               end
            end
         end
         default: begin
            state_d = ST_GAP;
            gap_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_GAP;
         gap_q   <= '0;
         idx_q   <= '0;
         data_q  <= SEED;
         last_q  <= LAST_RST;
         beats_q <= '0;
      end else begin
         state_q <= state_d;
         gap_q   <= gap_d;
         idx_q   <= idx_d;
         data_q  <= data_d;
         last_q  <= last_d;
         beats_q <= beats_d;
      end
   end

   assign valid_o = (state_q == ST_VALID);
   assign data_o  = data_q;
   assign last_o  = last_q;
   assign beats_o = beats_q;

endmodule
